imm_alloc: RTL

- Write-side manager for the 4-wide immediate storage array used at dispatch.
- Owns a busy bitmap of rows, where each row is 4 consecutive immediate slots. It allocates the lowest free row per dispatch group and returns the 4 slot indices to the issue queue.
- Registers the 4 immediates and drives the array's write port (write-enable, one-hot row select, 4 data words) one cycle later.
- Rows are released by commit via a one-hot free mask, or all at once by flush.

---
 rtl/imm_alloc.sv | 104 ++++++++++
 1 files changed

// File: rtl/imm_alloc.sv
// Write-side manager for the 4-wide immediate storage array: grants the
// lowest free row per dispatch group and drives the array write port a cycle later.
module imm_alloc #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_req,
  input  logic [WIDTH-1:0]                i_imm0,
  input  logic [WIDTH-1:0]                i_imm1,
  input  logic [WIDTH-1:0]                i_imm2,
  input  logic [WIDTH-1:0]                i_imm3,
  output logic                            o_ready,
  output logic [$clog2(SIZE)-1:0]         o_idx0,
  output logic [$clog2(SIZE)-1:0]         o_idx1,
  output logic [$clog2(SIZE)-1:0]         o_idx2,
  output logic [$clog2(SIZE)-1:0]         o_idx3,
  input  logic                            i_free,
  input  logic [SIZE/4-1:0]               i_free_row,
  input  logic                            i_flush,
  output logic                            o_we,
  output logic [SIZE/4-1:0]               o_waddr,
  output logic [WIDTH-1:0]                o_wdata0,
  output logic [WIDTH-1:0]                o_wdata1,
  output logic [WIDTH-1:0]                o_wdata2,
  output logic [WIDTH-1:0]                o_wdata3,
  output logic [$clog2(SIZE/4):0]         o_busy_cnt
);

  localparam int unsigned ROWS  = SIZE / 4;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned IDX_W = $clog2(SIZE);
  localparam int unsigned CNT_W = $clog2(ROWS) + 1;

  logic [ROWS-1:0]  busy;
  logic [ROWS-1:0]  busy_nxt;
  logic [ROWS-1:0]  sel_oh;
  logic [ROW_W-1:0] sel;
  logic [CNT_W-1:0] cnt_nxt;
  logic             alloc;

  // Lowest free row; scanned downward so the last hit is the lowest index.
  always_comb begin
    sel = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!busy[r]) sel = ROW_W'(r);
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  assign o_ready = ~(&busy) & ~i_flush & ~i_rst;
  assign alloc   = i_req & o_ready;

  assign o_idx0 = IDX_W'({sel, 2'd0});
  assign o_idx1 = IDX_W'({sel, 2'd1});
  assign o_idx2 = IDX_W'({sel, 2'd2});
  assign o_idx3 = IDX_W'({sel, 2'd3});

  // Next busy map: release and grant both apply; flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    if (i_free) busy_nxt = busy_nxt & ~i_free_row;
    if (alloc)  busy_nxt = busy_nxt | sel_oh;
    if (i_flush) busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
    end
  end

  // Busy state and registered write port; waddr clears whenever we clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= '0;
      o_busy_cnt <= '0;
      o_we       <= 1'b0;
      o_waddr    <= '0;
      o_wdata0   <= '0;
      o_wdata1   <= '0;
      o_wdata2   <= '0;
      o_wdata3   <= '0;
    end else begin
      busy       <= busy_nxt;
      o_busy_cnt <= cnt_nxt;
      o_we       <= alloc;
      o_waddr    <= alloc ? sel_oh : '0;
      if (alloc) begin
        o_wdata0 <= i_imm0;
        o_wdata1 <= i_imm1;
        o_wdata2 <= i_imm2;
        o_wdata3 <= i_imm3;
      end
    end
  end

endmodule
